// File: rtl/mem_stage_hs_pkg.sv
// Shared types for the memory stage: access sizes, exception causes, the writeback
// pass-through bundle and the bus FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam logic [3:0] EC_INSN_MISALIGN  = 4'd0;
    localparam logic [3:0] EC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EC_STORE_FAULT    = 4'd7;

    // pc/next_pc/csr_data are sized for the widest supported XLEN
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] next_pc;
        logic [63:0] csr_data;
        logic [1:0]  write_select;
        logic [4:0]  rd;
        logic [11:0] csr_address;
        logic        csr_write;
        logic        mret;
        logic        wfi;
    } wb_info_t;

    function automatic logic addr_aligned(input size_e sz, input logic [2:0] a, input logic wide);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return a[0] == 1'b0;
            SZ_W:    return a[1:0] == 2'b00;
            default: return wide && (a == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Request/grant + response data bus between the memory stage (master) and memory (slave).
// One outstanding transaction; fields are held stable from request until grant.
interface mem_stage_hs_if #(
    parameter int XLEN = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN/8-1:0] bus_be;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic              bus_err;
    logic [XLEN-1:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_err, bus_rdata
    );
endinterface

// File: rtl/mem_stage_hs_load_align.sv
// Load data alignment: shift raw bus data down to its byte lane, then sign/zero-extend.
// Purely combinational, no backpressure.
module load_align
    import mem_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int LANE_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]   rdata_i,
    input  logic [LANE_W-1:0] lane_i,
    input  size_e             size_i,
    input  logic              signed_i,
    output logic [XLEN-1:0]   data_o
);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep_mask;
    logic            sign_bit;

    assign shifted = rdata_i >> {lane_i, 3'b000};

    always_comb begin
        keep_mask = '1;
        sign_bit  = shifted[XLEN-1];
        case (size_i)
            SZ_B: begin keep_mask = XLEN'(8'hFF);         sign_bit = shifted[7];  end
            SZ_H: begin keep_mask = XLEN'(16'hFFFF);      sign_bit = shifted[15]; end
            SZ_W: begin keep_mask = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
            default: ;
        endcase
    end

    assign data_o = (shifted & keep_mask) | ({XLEN{signed_i & sign_bit}} & ~keep_mask);

endmodule

// File: rtl/mem_stage_hs.sv
// Execute->writeback memory stage on a req/gnt bus; plain slots take 1 cycle, memory ops 2+ (gnt/rvalid waits add).
// Raises busy while a transaction is in flight; stall_in freezes writeback (DONE holds a captured response).
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int WB_W = $bits(wb_info_t)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              exception_in,
    input  logic [3:0]        ecause_in,
    input  logic [XLEN-1:0]   alu_data_in,
    input  logic [XLEN-1:0]   rs2_data_in,
    input  logic              branch_taken_in,
    input  logic              load_in,
    input  logic              store_in,
    input  logic              signed_in,
    input  logic [1:0]        size_in,
    input  logic [WB_W-1:0]   wb_info_in,
    input  logic              stall_in,
    input  logic              invalidate,
    output logic              busy,
    output logic              branch_taken,
    output logic [XLEN-1:0]   branch_address,
    mem_stage_hs_if.master    bus,
    output logic              valid_out,
    output logic              exception_out,
    output logic [3:0]        ecause_out,
    output logic [XLEN-1:0]   alu_data_out,
    output logic [XLEN-1:0]   load_data_out,
    output logic [WB_W-1:0]   wb_info_out
);
    localparam int BE_W   = XLEN/8;
    localparam int LANE_W = $clog2(BE_W);

    state_e            state_q, state_d;
    logic              killed_q, killed_d;
    logic [XLEN-1:0]   addr_q, wdata_q, rsp_data_q;
    logic [BE_W-1:0]   be_q;
    logic              we_q, signed_q, rsp_err_q;
    size_e             size_q;

    logic              valid_q, valid_d, exc_q, exc_d;
    logic [3:0]        ecause_q, ecause_d;
    logic [XLEN-1:0]   alu_q, alu_d, ld_q, ld_d;
    logic [WB_W-1:0]   wbinfo_q, wbinfo_d;

    size_e             size_c;
    logic [LANE_W-1:0] lane_c;
    logic [BE_W-1:0]   be_c;
    logic [XLEN-1:0]   wdata_c, ld_aligned, rsp_data;
    logic              live, br_mis, is_mem, aligned, mis_mem, mem_op;
    logic              in_flight, rsp_done, kill_now, wb_fire, rsp_err;

    assign size_c   = size_e'(size_in);
    assign lane_c   = alu_data_in[LANE_W-1:0];
    assign live     = valid_in && !invalidate && !exception_in;
    assign br_mis   = live && branch_taken_in && (alu_data_in[1:0] != 2'b00);
    assign is_mem   = load_in || store_in;
    assign aligned  = addr_aligned(size_c, alu_data_in[2:0], XLEN == 64);
    assign mis_mem  = live && is_mem && !aligned;
    assign mem_op   = live && is_mem && aligned;

    assign in_flight = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign rsp_done  = (state_q == ST_WAIT) && bus.bus_rvalid;
    // an invalidate landing mid-transaction must also kill a response completing this cycle
    assign kill_now  = killed_q || (invalidate && in_flight);
    assign wb_fire   = !stall_in && (((state_q == ST_IDLE) && !mem_op) || rsp_done || (state_q == ST_DONE));
    assign rsp_err   = rsp_done ? bus.bus_err : rsp_err_q;
    assign rsp_data  = rsp_done ? ld_aligned : rsp_data_q;

    assign branch_taken   = rst_n && live && branch_taken_in && !br_mis;
    assign branch_address = alu_data_in;
    // busy is held through a killed drain so no younger slot slips in behind the bus
    assign busy = rst_n && ((((mem_op || in_flight) && !(rsp_done && !stall_in)) && (state_q != ST_DONE))
                            || ((state_q == ST_DONE) && stall_in));

    always_comb begin : bus_fields
        be_c    = BE_W'(8'hFF) << lane_c;
        wdata_c = rs2_data_in;
        case (size_c)
            SZ_B: begin be_c = BE_W'(8'h01) << lane_c; wdata_c = {(XLEN/8){rs2_data_in[7:0]}};   end
            SZ_H: begin be_c = BE_W'(8'h03) << lane_c; wdata_c = {(XLEN/16){rs2_data_in[15:0]}}; end
            SZ_W: begin be_c = BE_W'(8'h0F) << lane_c; wdata_c = {(XLEN/32){rs2_data_in[31:0]}}; end
            default: ;
        endcase
    end

    assign bus.bus_req   = rst_n && ((state_q == ST_IDLE) ? mem_op : (state_q == ST_REQ));
    assign bus.bus_we    = (state_q == ST_REQ) ? we_q    : store_in;
    assign bus.bus_addr  = (state_q == ST_REQ) ? addr_q  : alu_data_in;
    assign bus.bus_be    = (state_q == ST_REQ) ? be_q    : be_c;
    assign bus.bus_wdata = (state_q == ST_REQ) ? wdata_q : wdata_c;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i  (bus.bus_rdata),
        .lane_i   (addr_q[LANE_W-1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (ld_aligned)
    );

    always_comb begin : fsm_next
        state_d  = state_q;
        killed_d = killed_q || (invalidate && in_flight);
        case (state_q)
            ST_IDLE: if (mem_op)          state_d = bus.bus_gnt ? ST_WAIT : ST_REQ;
            ST_REQ:  if (bus.bus_gnt)     state_d = ST_WAIT;
            ST_WAIT: if (bus.bus_rvalid)  state_d = stall_in ? ST_DONE : ST_IDLE;
            default: if (!stall_in)       state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) killed_d = 1'b0;
    end

    always_comb begin : wb_next
        valid_d  = 1'b0;
        exc_d    = 1'b0;
        ecause_d = ecause_q;
        alu_d    = alu_q;
        ld_d     = ld_q;
        wbinfo_d = wbinfo_q;
        if (wb_fire) begin
            wbinfo_d = wb_info_in;
            if (state_q == ST_IDLE) begin
                valid_d = valid_in && !invalidate;
                exc_d   = valid_d && (exception_in || br_mis || mis_mem);
                alu_d   = alu_data_in;
                ld_d    = '0;
                if (exception_in)  ecause_d = ecause_in;
                else if (mis_mem)  ecause_d = load_in ? EC_LOAD_MISALIGN : EC_STORE_MISALIGN;
                else               ecause_d = EC_INSN_MISALIGN;
            end else begin
                valid_d  = !kill_now;
                exc_d    = valid_d && rsp_err;
                alu_d    = addr_q;
                ld_d     = rsp_err ? '0 : rsp_data;
                ecause_d = !rsp_err ? 4'd0 : (we_q ? EC_STORE_FAULT : EC_LOAD_FAULT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            killed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            signed_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            exc_q      <= 1'b0;
            ecause_q   <= '0;
            alu_q      <= '0;
            ld_q       <= '0;
            wbinfo_q   <= '0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            if (state_q == ST_IDLE) begin
                addr_q   <= alu_data_in;
                wdata_q  <= wdata_c;
                be_q     <= be_c;
                we_q     <= store_in;
                size_q   <= size_c;
                signed_q <= signed_in;
            end
            if (rsp_done) begin
                rsp_data_q <= ld_aligned;
                rsp_err_q  <= bus.bus_err;
            end
            valid_q  <= valid_d;
            exc_q    <= exc_d;
            ecause_q <= ecause_d;
            alu_q    <= alu_d;
            ld_q     <= ld_d;
            wbinfo_q <= wbinfo_d;
        end
    end

    assign valid_out     = valid_q;
    assign exception_out = exc_q;
    assign ecause_out    = ecause_q;
    assign alu_data_out  = alu_q;
    assign load_data_out = ld_q;
    assign wb_info_out   = wbinfo_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: an XLEN=32 instance for the main sequence, an XLEN=64
// instance for doubleword and wide sign-extension loads.
module tb_mem_stage_hs;
    import mem_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   bcnt;

    // XLEN=32 instance signals
    logic        valid_in, exception_in, branch_taken_in, load_in, store_in, signed_in;
    logic        stall_in, invalidate;
    logic [3:0]  ecause_in;
    logic [31:0] alu_data_in, rs2_data_in;
    logic [1:0]  size_in;
    wb_info_t    wbi32, wbo32;
    logic        busy, branch_taken, valid_out, exception_out;
    logic [31:0] branch_address, alu_data_out, load_data_out;
    logic [3:0]  ecause_out;

    // XLEN=64 instance signals
    logic        w_valid_in, w_exception_in, w_branch_taken_in, w_load_in, w_store_in, w_signed_in;
    logic        w_stall_in, w_invalidate;
    logic [3:0]  w_ecause_in;
    logic [63:0] w_alu_data_in, w_rs2_data_in;
    logic [1:0]  w_size_in;
    wb_info_t    wbi64, wbo64;
    logic        w_busy, w_branch_taken, w_valid_out, w_exception_out;
    logic [63:0] w_branch_address, w_alu_data_out, w_load_data_out;
    logic [3:0]  w_ecause_out;

    mem_stage_hs_if #(.XLEN(32)) bus32 ();
    mem_stage_hs_if #(.XLEN(64)) bus64 ();

    mem_stage_hs #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
        .alu_data_in(alu_data_in), .rs2_data_in(rs2_data_in),
        .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
        .signed_in(signed_in), .size_in(size_in), .wb_info_in(wbi32),
        .stall_in(stall_in), .invalidate(invalidate),
        .busy(busy), .branch_taken(branch_taken), .branch_address(branch_address),
        .bus(bus32),
        .valid_out(valid_out), .exception_out(exception_out), .ecause_out(ecause_out),
        .alu_data_out(alu_data_out), .load_data_out(load_data_out), .wb_info_out(wbo32)
    );

    mem_stage_hs #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(w_valid_in), .exception_in(w_exception_in), .ecause_in(w_ecause_in),
        .alu_data_in(w_alu_data_in), .rs2_data_in(w_rs2_data_in),
        .branch_taken_in(w_branch_taken_in), .load_in(w_load_in), .store_in(w_store_in),
        .signed_in(w_signed_in), .size_in(w_size_in), .wb_info_in(wbi64),
        .stall_in(w_stall_in), .invalidate(w_invalidate),
        .busy(w_busy), .branch_taken(w_branch_taken), .branch_address(w_branch_address),
        .bus(bus64),
        .valid_out(w_valid_out), .exception_out(w_exception_out), .ecause_out(w_ecause_out),
        .alu_data_out(w_alu_data_out), .load_data_out(w_load_data_out), .wb_info_out(wbo64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle32();
        valid_in = 0; exception_in = 0; ecause_in = 0; alu_data_in = 0; rs2_data_in = 0;
        branch_taken_in = 0; load_in = 0; store_in = 0; signed_in = 0; size_in = 0;
        stall_in = 0; invalidate = 0; wbi32 = '0;
        bus32.bus_gnt = 0; bus32.bus_rvalid = 0; bus32.bus_err = 0; bus32.bus_rdata = 0;
    endtask

    task automatic idle64();
        w_valid_in = 0; w_exception_in = 0; w_ecause_in = 0; w_alu_data_in = 0; w_rs2_data_in = 0;
        w_branch_taken_in = 0; w_load_in = 0; w_store_in = 0; w_signed_in = 0; w_size_in = 0;
        w_stall_in = 0; w_invalidate = 0; wbi64 = '0;
        bus64.bus_gnt = 0; bus64.bus_rvalid = 0; bus64.bus_err = 0; bus64.bus_rdata = 0;
    endtask

    // Memory op on the 32-bit instance: drives the slot, caller sets bus responses
    task automatic mem32(input logic ld, input logic sgn, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
        idle32();
        valid_in = 1; load_in = ld; store_in = !ld; signed_in = sgn; size_in = sz;
        alu_data_in = addr; rs2_data_in = wd;
    endtask

    initial begin
        idle32();
        idle64();
        // reset with a live load/branch on the inputs: outputs must stay gated
        rst_n = 0;
        valid_in = 1; load_in = 1; size_in = 2'b10; alu_data_in = 32'h1000; branch_taken_in = 1;
        w_valid_in = 1; w_load_in = 1; w_size_in = 2'b11; w_alu_data_in = 64'h8;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_bus_req", bus32.bus_req, 0);
        chk("rst_branch_taken", branch_taken, 0);
        chk("rst_w_bus_req", bus64.bus_req, 0);
        tick(); tick();
        chk("rst_valid_out", valid_out, 0);
        chk("rst_exception_out", exception_out, 0);
        chk("rst_ecause_out", ecause_out, 0);
        chk("rst_load_data", load_data_out, 0);
        chk("rst_alu_data", alu_data_out, 0);
        chk("rst_wb_pc", wbo32.pc, 0);
        chk("rst_w_load_data", w_load_data_out, 0);
        idle32();
        idle64();
        rst_n = 1;
        tick();

        // plain ALU slot: one-cycle pass-through
        valid_in = 1; alu_data_in = 32'h55; wbi32.pc = 64'h100; wbi32.rd = 5'd9;
        #1 chk("alu_busy", busy, 0);
        tick();
        chk("alu_valid", valid_out, 1);
        chk("alu_data", alu_data_out, 32'h55);
        chk("alu_wb_pc", wbo32.pc, 64'h100);
        chk("alu_wb_rd", wbo32.rd, 5'd9);
        chk("alu_exc", exception_out, 0);
        idle32();
        tick();
        chk("alu_pulse", valid_out, 0);

        // branches: aligned redirects, misaligned raises cause 0
        valid_in = 1; branch_taken_in = 1; alu_data_in = 32'h4000;
        #1;
        chk("br_taken", branch_taken, 1);
        chk("br_addr", branch_address, 32'h4000);
        tick();
        chk("br_exc", exception_out, 0);
        alu_data_in = 32'h4002;
        #1 chk("br_mis_taken", branch_taken, 0);
        tick();
        chk("br_mis_exc", exception_out, 1);
        chk("br_mis_cause", ecause_out, 0);

        // LB signed at 0x1003, gnt in issue cycle, rvalid next cycle
        mem32(1, 1, 2'b00, 32'h1003, 0);
        bus32.bus_gnt = 1;
        #1;
        chk("lb_req", bus32.bus_req, 1);
        chk("lb_we", bus32.bus_we, 0);
        chk("lb_be", bus32.bus_be, 4'h8);
        chk("lb_addr", bus32.bus_addr, 32'h1003);
        chk("lb_busy", busy, 1);
        tick();
        chk("lb_valid_e1", valid_out, 0);
        bus32.bus_gnt = 0; bus32.bus_rvalid = 1; bus32.bus_rdata = 32'h80FF_FFFF;
        #1;
        chk("lb_busy_rsp", busy, 0);
        chk("lb_req_wait", bus32.bus_req, 0);
        tick();
        chk("lb_valid_e2", valid_out, 1);
        chk("lb_data", load_data_out, 32'hFFFF_FF80);
        chk("lb_alu", alu_data_out, 32'h1003);
        chk("lb_exc", exception_out, 0);
        idle32();
        tick();
        chk("lb_pulse", valid_out, 0);

        // SH at 0x2002: lane-replicated halfword
        mem32(0, 0, 2'b01, 32'h2002, 32'h1234_ABCD);
        bus32.bus_gnt = 1;
        #1;
        chk("sh_we", bus32.bus_we, 1);
        chk("sh_be", bus32.bus_be, 4'hC);
        chk("sh_wdata", bus32.bus_wdata, 32'hABCD_ABCD);
        tick();
        bus32.bus_gnt = 0; bus32.bus_rvalid = 1;
        tick();
        chk("sh_valid", valid_out, 1);
        chk("sh_exc", exception_out, 0);

        // misaligned accesses: no request, one-cycle exception
        mem32(1, 0, 2'b10, 32'h0006, 0);
        #1;
        chk("lw_mis_req", bus32.bus_req, 0);
        chk("lw_mis_busy", busy, 0);
        tick();
        chk("lw_mis_exc", exception_out, 1);
        chk("lw_mis_cause", ecause_out, 4);
        chk("lw_mis_valid", valid_out, 1);
        mem32(0, 0, 2'b01, 32'h0001, 0);
        tick();
        chk("sh_mis_cause", ecause_out, 6);
        mem32(1, 0, 2'b11, 32'h0000, 0);
        #1 chk("d32_req", bus32.bus_req, 0);
        tick();
        chk("d32_exc", exception_out, 1);
        chk("d32_cause", ecause_out, 4);
        idle32();
        tick();

        // gnt delayed 3 cycles: bus fields registered through REQ
        bcnt = 0;
        mem32(0, 0, 2'b10, 32'h5000, 32'hCAFE_F00D);
        #1 chk("gd_req_c0", bus32.bus_req, 1);
        bcnt += int'(busy);
        tick();
        rs2_data_in = 32'h0;
        #1;
        chk("gd_addr_c1", bus32.bus_addr, 32'h5000);
        chk("gd_be_c1", bus32.bus_be, 4'hF);
        chk("gd_wdata_c1", bus32.bus_wdata, 32'hCAFE_F00D);
        chk("gd_req_c1", bus32.bus_req, 1);
        bcnt += int'(busy);
        tick();
        #1 chk("gd_wdata_c2", bus32.bus_wdata, 32'hCAFE_F00D);
        bcnt += int'(busy);
        tick();
        bus32.bus_gnt = 1;
        #1 chk("gd_req_c3", bus32.bus_req, 1);
        bcnt += int'(busy);
        tick();
        bus32.bus_gnt = 0; bus32.bus_rvalid = 1;
        #1 bcnt += int'(busy);
        tick();
        chk("gd_busy_cycles", bcnt, 4);
        chk("gd_valid", valid_out, 1);

        // invalidate while in REQ: transaction completes, result is dropped
        mem32(1, 0, 2'b10, 32'h6000, 0);
        tick();
        invalidate = 1;
        #1 chk("kill_req_held", bus32.bus_req, 1);
        tick();
        invalidate = 0; bus32.bus_gnt = 1;
        #1 chk("kill_busy", busy, 1);
        tick();
        chk("kill_valid_w", valid_out, 0);
        bus32.bus_gnt = 0; bus32.bus_rvalid = 1; bus32.bus_rdata = 32'h1111_2222;
        tick();
        chk("kill_valid", valid_out, 0);
        mem32(1, 0, 2'b10, 32'h6004, 0);
        bus32.bus_gnt = 1;
        tick();
        bus32.bus_gnt = 0; bus32.bus_rvalid = 1; bus32.bus_rdata = 32'h3333_4444;
        tick();
        chk("post_kill_valid", valid_out, 1);
        chk("post_kill_data", load_data_out, 32'h3333_4444);

        // bus errors
        mem32(0, 0, 2'b10, 32'h7000, 32'h55);
        bus32.bus_gnt = 1;
        tick();
        bus32.bus_gnt = 0; bus32.bus_rvalid = 1; bus32.bus_err = 1;
        tick();
        chk("st_err_exc", exception_out, 1);
        chk("st_err_cause", ecause_out, 7);
        mem32(1, 1, 2'b10, 32'h7004, 0);
        bus32.bus_gnt = 1;
        tick();
        bus32.bus_gnt = 0; bus32.bus_rvalid = 1; bus32.bus_err = 1; bus32.bus_rdata = 32'hFFFF_FFFF;
        tick();
        chk("ld_err_cause", ecause_out, 5);
        chk("ld_err_data", load_data_out, 0);

        // response under stall: DONE holds the captured data
        mem32(1, 0, 2'b01, 32'h8002, 0);
        bus32.bus_gnt = 1;
        tick();
        bus32.bus_gnt = 0; bus32.bus_rvalid = 1; bus32.bus_rdata = 32'hBEEF_1234; stall_in = 1;
        #1 chk("stl_busy_w", busy, 1);
        tick();
        chk("stl_valid_1", valid_out, 0);
        bus32.bus_rvalid = 0; bus32.bus_rdata = 32'h0;
        #1 chk("stl_busy_d", busy, 1);
        tick();
        chk("stl_valid_2", valid_out, 0);
        stall_in = 0;
        #1 chk("stl_busy_rel", busy, 0);
        tick();
        chk("stl_valid", valid_out, 1);
        chk("stl_data", load_data_out, 32'h0000_BEEF);
        idle32();

        // XLEN=64: doubleword load, then signed word from the upper lane
        w_valid_in = 1; w_load_in = 1; w_size_in = 2'b11; w_alu_data_in = 64'h8;
        bus64.bus_gnt = 1;
        #1;
        chk("ld64_req", bus64.bus_req, 1);
        chk("ld64_be", bus64.bus_be, 8'hFF);
        tick();
        bus64.bus_gnt = 0; bus64.bus_rvalid = 1; bus64.bus_rdata = 64'h8000_0000_0000_0001;
        tick();
        chk("ld64_valid", w_valid_out, 1);
        chk("ld64_data", w_load_data_out, 64'h8000_0000_0000_0001);
        idle64();
        w_valid_in = 1; w_load_in = 1; w_signed_in = 1; w_size_in = 2'b10; w_alu_data_in = 64'hC;
        bus64.bus_gnt = 1;
        #1 chk("lw64_be", bus64.bus_be, 8'hF0);
        tick();
        bus64.bus_gnt = 0; bus64.bus_rvalid = 1; bus64.bus_rdata = 64'h8000_0000_0000_0000;
        tick();
        chk("lw64_data", w_load_data_out, 64'hFFFF_FFFF_8000_0000);
        idle64();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
